// File: rtl/game_io_hub_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_io_hub_if
//  Description : Data-memory side bus between the processor load/store port
//                and the game I/O hub register window.
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_io_hub_if;
    logic [11:0] addr;
    logic        wren;
    logic        rden;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    // Processor side drives address/strobes and consumes the read return.
    modport master (
        output addr, wren, rden, wdata,
        input  rdata, hit
    );

    // Peripheral side decodes the access and returns data plus the hit flag.
    modport slave (
        input  addr, wren, rden, wdata,
        output rdata, hit
    );
endinterface
`default_nettype wire

// File: rtl/game_io_hub.sv
`default_nettype none
// ============================================================================
//  Module      : game_io_hub
//  Description : Memory-mapped game I/O peripheral: free-running LFSR random
//                source, debounced button channels feeding a press-event
//                FIFO, and latched / timed-flash LED drives.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_io_hub #(
    parameter int          NUM_CH          = 4,
    parameter logic [11:0] BASE_ADDR       = 12'd5,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          FLASH_CYCLES    = 8,
    parameter logic [31:0] LFSR_SEED       = 32'hACE1_0001
) (
    input  logic              clock,
    input  logic              reset,
    game_io_hub_if.slave      bus,
    input  logic [NUM_CH-1:0] buttons,
    output logic [NUM_CH-1:0] leds
);

    // Galois taps 32,22,2,1 for a right-shifting register.
    localparam logic [31:0] c_lfsr_mask = 32'h8020_0003;

    localparam logic [1:0] c_off_random = 2'd0;
    localparam logic [1:0] c_off_led    = 2'd1;
    localparam logic [1:0] c_off_event  = 2'd2;
    localparam logic [1:0] c_off_status = 2'd3;

    localparam int c_db_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_db_w-1:0] c_db_one  = c_db_w'(1);

    localparam int c_fl_w = $clog2(FLASH_CYCLES + 1);
    localparam logic [c_fl_w-1:0] c_fl_load = c_fl_w'(FLASH_CYCLES);
    localparam logic [c_fl_w-1:0] c_fl_one  = c_fl_w'(1);

    localparam int c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_aw-1:0] c_ptr_one  = c_aw'(1);
    localparam logic [c_aw:0]   c_cnt_one  = (c_aw + 1)'(1);
    localparam logic [c_aw:0]   c_cnt_full = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [4:0]      c_num_ch5  = 5'(NUM_CH);

    // ------------------------------------------------------------------
    // Address decode and access strobes
    // ------------------------------------------------------------------
    logic [12:0] w_addr_ext;
    logic        w_hit;
    logic [1:0]  w_offset;
    logic        w_wr_random;
    logic        w_wr_led;
    logic        w_rd_event;
    logic        w_rd_status;
    logic [4:0]  w_led_ch;
    logic        w_led_on;
    logic        w_led_timed;

    assign w_addr_ext  = {1'b0, bus.addr};
    assign w_hit       = (w_addr_ext >= {1'b0, BASE_ADDR}) &&
                         (w_addr_ext <= ({1'b0, BASE_ADDR} + 13'd3));
    // Only the low two bits of (addr - BASE_ADDR) matter inside the window.
    assign w_offset    = bus.addr[1:0] - BASE_ADDR[1:0];
    assign w_wr_random = bus.wren && w_hit && (w_offset == c_off_random);
    assign w_wr_led    = bus.wren && w_hit && (w_offset == c_off_led);
    assign w_rd_event  = bus.rden && w_hit && (w_offset == c_off_event);
    assign w_rd_status = bus.rden && w_hit && (w_offset == c_off_status);
    assign w_led_ch    = bus.wdata[5:1];
    assign w_led_on    = bus.wdata[0];
    assign w_led_timed = bus.wdata[8];

    // ------------------------------------------------------------------
    // LFSR random source
    // ------------------------------------------------------------------
    logic [31:0] lfsr_q, lfsr_d;

    // Advance one Galois step, unless a nonzero reseed is written this cycle.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? c_lfsr_mask : 32'h0);
        if (w_wr_random && (bus.wdata != 32'h0)) begin
            lfsr_d = bus.wdata;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel button debounce and LED drive
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] w_rise;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic              sync1_q;
            logic              sync2_q;
            logic              db_q, db_d;
            logic [c_db_w-1:0] cnt_q, cnt_d;
            logic              led_q, led_d;
            logic [c_fl_w-1:0] timer_q, timer_d;
            logic              w_led_sel;

            // Out-of-range channel numbers never match any channel.
            assign w_led_sel = w_wr_led && (w_led_ch == 5'(i));

            // Count consecutive cycles of disagreement; toggle once it has held long enough.
            always_comb begin
                db_d  = db_q;
                cnt_d = '0;
                if (sync2_q != db_q) begin
                    if (cnt_q == c_db_last) begin
                        db_d  = ~db_q;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + c_db_one;
                    end
                end
            end

            // LED latch / timed flash; a write always overrides a running timer.
            always_comb begin
                led_d   = led_q;
                timer_d = timer_q;
                if (w_led_sel) begin
                    if (w_led_timed && w_led_on) begin
                        led_d   = 1'b1;
                        timer_d = c_fl_load;
                    end else begin
                        led_d   = w_led_on;
                        timer_d = '0;
                    end
                end else if (timer_q != '0) begin
                    timer_d = timer_q - c_fl_one;
                    if (timer_q == c_fl_one) begin
                        led_d = 1'b0;
                    end
                end
            end

            // Channel state registers.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    db_q    <= 1'b0;
                    cnt_q   <= '0;
                    led_q   <= 1'b0;
                    timer_q <= '0;
                end else begin
                    sync1_q <= buttons[i];
                    sync2_q <= sync1_q;
                    db_q    <= db_d;
                    cnt_q   <= cnt_d;
                    led_q   <= led_d;
                    timer_q <= timer_d;
                end
            end

            assign w_rise[i] = db_d & ~db_q;
            assign leds[i]   = led_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pending presses and event FIFO
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] w_push_sel;
    logic [4:0]        w_push_idx;
    logic [4:0]        fifo_q [FIFO_DEPTH];
    logic [4:0]        fifo_d [FIFO_DEPTH];
    logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_aw:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              w_empty;
    logic              w_full;
    logic              w_push_req;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // Lowest-index pending channel wins the single push slot.
    always_comb begin
        w_push_idx = 5'd0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                w_push_idx = 5'(k);
            end
        end
    end

    assign w_push_sel = pending_q & (~pending_q + NUM_CH'(1));
    assign pending_d  = (pending_q & ~w_push_sel) | w_rise;

    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == c_cnt_full);
    assign w_push_req = |pending_q;
    assign w_pop      = w_rd_event && !w_empty;
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    // A drop in the same cycle as a STATUS read keeps the flag set.
    assign ovf_d      = (ovf_q && !w_rd_status) || w_drop;

    // FIFO storage, pointers and occupancy.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            fifo_d[wr_ptr_q] = w_push_idx;
            wr_ptr_d         = wr_ptr_q + c_ptr_one;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + c_cnt_one;
        end else if (w_pop && !w_push) begin
            count_d = count_q - c_cnt_one;
        end
    end

    // Shared state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q    <= LFSR_SEED;
            pending_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                fifo_q[k] <= 5'd0;
            end
        end else begin
            lfsr_q    <= lfsr_d;
            pending_q <= pending_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            fifo_q    <= fifo_d;
        end
    end

    // ------------------------------------------------------------------
    // Read return
    // ------------------------------------------------------------------
    logic [31:0] w_rdata;
    logic [4:0]  w_count5;

    assign w_count5 = 5'(count_q);

    // Combinational read mux; zero outside the window and for write-only LED.
    always_comb begin
        w_rdata = 32'h0;
        if (w_hit) begin
            case (w_offset)
                c_off_random: w_rdata = lfsr_q;
                c_off_event: begin
                    if (!w_empty) begin
                        w_rdata = {1'b1, 26'h0, fifo_q[rd_ptr_q]};
                    end
                end
                c_off_status: w_rdata = {11'h0, c_num_ch5, 3'h0, w_count5,
                                         5'h0, ovf_q, w_full, w_empty};
                default: w_rdata = 32'h0;
            endcase
        end
    end

    assign bus.rdata = w_rdata;
    assign bus.hit   = w_hit;

endmodule
`default_nettype wire

// File: tb/tb_game_io_hub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_io_hub
//  Description : Directed self-checking bench for game_io_hub: decode table
//                under reset, LFSR, debounce/events, FIFO overflow, LEDs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_io_hub;

    localparam logic [11:0] c_a_random = 12'd5;
    localparam logic [11:0] c_a_led    = 12'd6;
    localparam logic [11:0] c_a_event  = 12'd7;
    localparam logic [11:0] c_a_status = 12'd8;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] buttons;
    logic [3:0] leds;

    game_io_hub_if bus ();

    game_io_hub #(
        .NUM_CH          (4),
        .BASE_ADDR       (12'd5),
        .DEBOUNCE_CYCLES (16),
        .FIFO_DEPTH      (4),
        .FLASH_CYCLES    (8),
        .LFSR_SEED       (32'hACE1_0001)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus.slave),
        .buttons (buttons),
        .leds    (leds)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [11:0] addr;
        logic        wren;
        logic        rden;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_hit;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Called just after a clock edge; returns just after the next edge.
    task automatic access(input logic [11:0] a, input logic w, input logic r,
                          input logic [31:0] d, output logic [31:0] rd);
        bus.addr  = a;
        bus.wren  = w;
        bus.rden  = r;
        bus.wdata = d;
        #1 rd = bus.rdata;
        @(posedge clock);
        #1;
        bus.wren = 1'b0;
        bus.rden = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input int ch);
        buttons[ch] = 1'b1;
        cycles(25);
        buttons[ch] = 1'b0;
        cycles(25);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          hi;
        int          seq [6];

        reset     = 1'b0;
        buttons   = 4'h0;
        bus.addr  = 12'd0;
        bus.wren  = 1'b0;
        bus.rden  = 1'b0;
        bus.wdata = 32'h0;

        // Decode table, applied with reset held: outputs depend on addr only.
        tbl[0] = '{12'd4,   1'b0, 1'b1, 32'h0,         32'h0,         1'b0};
        tbl[1] = '{12'd5,   1'b0, 1'b1, 32'h0,         32'hACE1_0001, 1'b1};
        tbl[2] = '{12'd5,   1'b1, 1'b0, 32'h1234_5678, 32'hACE1_0001, 1'b1};
        tbl[3] = '{12'd5,   1'b0, 1'b1, 32'h0,         32'hACE1_0001, 1'b1};
        tbl[4] = '{12'd6,   1'b1, 1'b1, 32'h0000_0101, 32'h0,         1'b1};
        tbl[5] = '{12'd7,   1'b0, 1'b1, 32'h0,         32'h0,         1'b1};
        tbl[6] = '{12'd8,   1'b0, 1'b1, 32'h0,         32'h0004_0001, 1'b1};
        tbl[7] = '{12'd9,   1'b0, 1'b1, 32'h0,         32'h0,         1'b0};
        tbl[8] = '{12'd0,   1'b0, 1'b1, 32'h0,         32'h0,         1'b0};
        tbl[9] = '{12'hFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b0};

        cycles(2);
        for (int i = 0; i < 10; i++) begin
            bus.addr  = tbl[i].addr;
            bus.wren  = tbl[i].wren;
            bus.rden  = tbl[i].rden;
            bus.wdata = tbl[i].wdata;
            #1;
            chk($sformatf("tbl%0d_rdata", i), bus.rdata, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_hit", i), {31'h0, bus.hit}, {31'h0, tbl[i].exp_hit});
            cycles(1);
        end
        bus.wren = 1'b0;
        bus.rden = 1'b0;
        chk("reset_leds", {28'h0, leds}, 32'h0);

        // LFSR start, first step, reseed, ignored zero write.
        reset = 1'b1;
        access(c_a_random, 1'b0, 1'b0, 32'h0, rd);
        chk("lfsr_cycle0", rd, 32'hACE1_0001);
        access(c_a_random, 1'b0, 1'b0, 32'h0, rd);
        chk("lfsr_cycle1", rd, 32'hD650_8003);
        access(c_a_random, 1'b1, 1'b0, 32'h0000_0001, rd);
        access(c_a_random, 1'b0, 1'b0, 32'h0, rd);
        chk("lfsr_reseed", rd, 32'h0000_0001);
        access(c_a_random, 1'b0, 1'b0, 32'h0, rd);
        chk("lfsr_after_reseed", rd, 32'h8020_0003);
        access(c_a_random, 1'b1, 1'b0, 32'h0, rd);
        chk("lfsr_before_zero_wr", rd, 32'hC030_0002);
        access(c_a_random, 1'b0, 1'b0, 32'h0, rd);
        chk("lfsr_zero_wr_ignored", rd, 32'h6018_0001);

        // Glitch then real press on channel 2.
        buttons[2] = 1'b1;
        cycles(5);
        buttons[2] = 1'b0;
        cycles(10);
        access(c_a_status, 1'b0, 1'b0, 32'h0, rd);
        chk("glitch_no_event", rd, 32'h0004_0001);
        buttons[2] = 1'b1;
        cycles(30);
        access(c_a_status, 1'b0, 1'b0, 32'h0, rd);
        chk("press2_status", rd, 32'h0004_0100);
        access(c_a_event, 1'b0, 1'b1, 32'h0, rd);
        chk("press2_event", rd, 32'h8000_0002);
        access(c_a_event, 1'b0, 1'b1, 32'h0, rd);
        chk("press2_empty", rd, 32'h0);
        buttons[2] = 1'b0;
        cycles(25);

        // Simultaneous presses enqueue in ascending index order.
        buttons = 4'b1010;
        cycles(25);
        access(c_a_status, 1'b0, 1'b0, 32'h0, rd);
        chk("dual_count2", rd, 32'h0004_0200);
        access(c_a_event, 1'b0, 1'b1, 32'h0, rd);
        chk("dual_first", rd, 32'h8000_0001);
        access(c_a_status, 1'b0, 1'b0, 32'h0, rd);
        chk("dual_count1", rd, 32'h0004_0100);
        access(c_a_event, 1'b0, 1'b1, 32'h0, rd);
        chk("dual_second", rd, 32'h8000_0003);
        access(c_a_status, 1'b0, 1'b0, 32'h0, rd);
        chk("dual_count0", rd, 32'h0004_0001);
        buttons = 4'b0000;
        cycles(25);

        // Six presses into a four-deep FIFO.
        seq = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 6; i++) begin
            press(seq[i]);
        end
        access(c_a_status, 1'b0, 1'b1, 32'h0, rd);
        chk("ovf_status", rd, 32'h0004_0406);
        access(c_a_status, 1'b0, 1'b0, 32'h0, rd);
        chk("ovf_cleared", rd, 32'h0004_0402);
        for (int i = 0; i < 4; i++) begin
            access(c_a_event, 1'b0, 1'b1, 32'h0, rd);
            chk($sformatf("ovf_pop%0d", i), rd, 32'h8000_0000 | 32'(i));
        end
        access(c_a_status, 1'b0, 1'b0, 32'h0, rd);
        chk("ovf_drained", rd, 32'h0004_0001);

        // LED timed flash, latched on, out-of-range channel, timed-off.
        access(c_a_led, 1'b1, 1'b0, 32'h0000_0101, rd);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (leds[0]) hi++;
            cycles(1);
        end
        chk("flash_width", 32'(hi), 32'd8);
        chk("flash_off", {28'h0, leds}, 32'h0);
        access(c_a_led, 1'b1, 1'b0, 32'h0000_0005, rd);
        chk("led2_on", {28'h0, leds}, 32'h4);
        cycles(20);
        chk("led2_latched", {28'h0, leds}, 32'h4);
        access(c_a_led, 1'b1, 1'b0, 32'h0000_000F, rd);
        chk("led_ch7_ignored", {28'h0, leds}, 32'h4);
        access(c_a_led, 1'b1, 1'b0, 32'h0000_0104, rd);
        chk("led2_timed_off", {28'h0, leds}, 32'h0);

        // Reset in the middle of a flash with two events queued.
        buttons = 4'b0101;
        cycles(25);
        buttons = 4'b0000;
        cycles(3);
        access(c_a_status, 1'b0, 1'b0, 32'h0, rd);
        chk("pre_reset_count2", rd, 32'h0004_0200);
        access(c_a_led, 1'b1, 1'b0, 32'h0000_0103, rd);
        cycles(2);
        chk("flash_running", {28'h0, leds}, 32'h2);
        reset = 1'b0;
        #1;
        chk("mid_reset_leds", {28'h0, leds}, 32'h0);
        bus.addr = c_a_status;
        #1;
        chk("mid_reset_status", bus.rdata, 32'h0004_0001);
        bus.addr = c_a_random;
        #1;
        chk("mid_reset_random", bus.rdata, 32'hACE1_0001);
        cycles(2);
        reset = 1'b1;
        access(c_a_random, 1'b0, 1'b0, 32'h0, rd);
        chk("restart_lfsr0", rd, 32'hACE1_0001);
        access(c_a_random, 1'b0, 1'b0, 32'h0, rd);
        chk("restart_lfsr1", rd, 32'hD650_8003);
        access(c_a_status, 1'b0, 1'b0, 32'h0, rd);
        chk("restart_status", rd, 32'h0004_0001);
        cycles(10);
        chk("restart_leds", {28'h0, leds}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_io_hub.md
Name: game_io_hub

Overview:
- Parametrised memory-mapped I/O peripheral for the game SoC, placed between the processor data-memory port and the RAM read mux.
- Provides a free-running LFSR random source, NUM_CH button channels and NUM_CH LEDs.
- Button channels are synchronised and debounced, and press events are queued in an event FIFO.
- LEDs support latched on/off and timed auto-off flash.
- Replaces the fixed single-purpose address decodes with a generalised register window.

Parameters:
NUM_CH, 4, number of button/LED channels (1..16)
BASE_ADDR, 12'd5, word address of register offset 0
DEBOUNCE_CYCLES, 16, cycles a synchronised input must hold stable before the debounced state changes (>=1)
FIFO_DEPTH, 4, event FIFO entries (power of two, 2..16)
FLASH_CYCLES, 8, LED on-time for timed-flash writes (>=1)
LFSR_SEED, 32'hACE10001, nonzero reset seed

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
addr  in  12  data-memory word address
wren  in  1  store strobe
rden  in  1  load strobe; one pulse per lw
wdata  in  32  store data
rdata  out  32  read data for decoded register, 0 when not hit
hit  out  1  addr in [BASE_ADDR, BASE_ADDR+3]; wrapper selects rdata over RAM
buttons  in  NUM_CH  raw asynchronous button inputs, active-high
leds  out  NUM_CH  LED drives, active-high

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 RANDOM: read returns LFSR; write of nonzero wdata reseeds; write of 0 is ignored.
  - 1 LED: write only; reads return 0.
  - 2 EVENT: read pops the FIFO head.
  - 3 STATUS: read only.
- hit and rdata are combinational from addr and current state. All side effects (pop, reseed, LED update, overflow clear) occur at the clock edge where the strobe is high and hit=1.
- Reset (reset=0, async):
  - LFSR=LFSR_SEED.
  - FIFO empty, overflow=0.
  - leds=0, all flash timers 0.
  - Sync flops, debounced state, debounce counters and pending register all 0.
  - rdata and hit depend only on addr, so during reset: rdata=0 for EVENT/STATUS/LED, LFSR_SEED for RANDOM.
  - Reset mid-operation discards queued events and in-progress flashes.
- LFSR: 32-bit Galois, taps 32,22,2,1. Advances every cycle except the cycle a reseed is written (it loads wdata instead). It never reaches 0.
- Button path, per channel:
  - 2-flop synchroniser, then a counter that increments while the synchronised value differs from the debounced state and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the value still differs, the debounced state toggles and the counter clears.
  - A debounced 0->1 transition sets that channel's pending bit. Releases generate no events.
  - Latency from a stable raw press to the pending bit: 2 + DEBOUNCE_CYCLES cycles.
- Event push:
  - At most one push per cycle: the lowest-index pending bit is pushed as a 5-bit channel index and its pending bit is cleared.
  - Simultaneous presses therefore enqueue in ascending index order on consecutive cycles.
  - Push when full, with no same-cycle pop: event dropped, pending bit cleared, overflow set (sticky).
  - Push and pop in the same cycle: both take effect, count unchanged, including when full.
- EVENT read:
  - Non-empty: rdata = {1'b1, 26'b0, index[4:0]}, and rden pops the head.
  - Empty: rdata=0 and rden has no effect.
- STATUS read:
  - rdata bits: [0] empty, [1] full, [2] overflow, [12:8] count, [20:16] NUM_CH, others 0.
  - rden on STATUS clears overflow. A push overflow in the same cycle sets it, and set wins.
- LED write fields: ch = wdata[5:1], on = wdata[0], timed = wdata[8].
  - ch >= NUM_CH: write ignored.
  - timed=0: leds[ch]=on, and the channel timer clears.
  - timed=1, on=1: leds[ch]=1 and timer=FLASH_CYCLES. The timer decrements each cycle; when it transitions 1->0, leds[ch]=0. A re-write restarts the timer.
  - timed=1, on=0: identical to timed=0, on=0.
- wren and rden together on the same address: both side effects apply independently.

Test Plan:
1. Reset release, no activity -> leds=0. Read STATUS rdata=32'h0004_0001 (NUM_CH=4, empty). Read RANDOM at cycle 0 = 32'hACE10001, next cycle = Galois step of the seed.
2. Press buttons[2] with a 5-cycle glitch, then hold 30 cycles (DEBOUNCE_CYCLES=16) -> glitch produces no event. Exactly one event; EVENT read = 32'h8000_0002, next EVENT read = 0.
3. Press buttons[3] and buttons[1] on the same cycle, held -> EVENT reads return index 1 then index 3. STATUS count goes 2->1->0.
4. Generate 6 presses with no pops (FIFO_DEPTH=4) -> STATUS = full|overflow (bits 1,2 set, count 4). First STATUS rden clears overflow. Four pops return the first four indices in order.
5. Write LED wdata=32'h0000_0101 (ch0, timed) -> leds[0]=1 for exactly 8 cycles, then 0. Write 32'h0000_0005 (ch2 on, latched) -> leds[2] stays 1. Write ch=7 -> no change.
6. Assert reset mid-flash with 2 events queued -> leds=0, FIFO empty, and after release the LFSR restarts from LFSR_SEED.
